// File: rtl/mul_pkg.sv
// Shared constants and types for the 16x16 multiplier and its request arbiter.
package mul_pkg;

    localparam int unsigned MUL16_LAT    = 2;
    localparam int unsigned MUL16_WARMUP = 3;

    typedef struct packed {
        logic       vld;
        logic [2:0] id;
    } mul_tag_t;

    typedef enum logic [0:0] {
        WARMUP = 1'b0,
        RUN    = 1'b1
    } mul_arb_state_e;

endpackage

// File: rtl/arb_rr_nnbit.sv
// Combinational round-robin picker: first eligible bit after i_ptr, wrapping.
module arb_rr_nnbit #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         i_elig,
    input  logic [$clog2(N)-1:0] i_ptr,
    output logic [N-1:0]         o_gnt,
    output logic [$clog2(N)-1:0] o_idx
);

    localparam int unsigned IW = $clog2(N);

    // Scan ptr+1 .. ptr+N modulo N and keep the first eligible hit.
    always_comb begin
        int unsigned j;
        logic        found;
        o_gnt = '0;
        o_idx = '0;
        found = 1'b0;
        j     = 0;
        for (int unsigned k = 1; k <= N; k++) begin
            j = (32'(i_ptr) + k) % N;
            if (!found && i_elig[j]) begin
                found    = 1'b1;
                o_gnt[j] = 1'b1;
                o_idx    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/mul_16bit_wallace.sv
// Pipelined signed 16x16 multiplier; reduction tree left to synthesis.
// o_cry flags a product that does not fit in 16 signed bits.
// o_end goes high a fixed number of cycles after reset and stays high.
module mul_16bit_wallace
    import mul_pkg::*;
#(
    parameter int unsigned LAT = MUL16_LAT
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [15:0] i_num_x,
    input  logic [15:0] i_num_y,
    output logic [31:0] o_res,
    output logic        o_cry,
    output logic        o_end
);

    localparam int unsigned PW = LAT - 1;

    logic [15:0]        in_x_q, in_y_q;
    logic [31:0]        res_q [PW];
    logic [31:0]        res_d [PW];
    logic [PW-1:0]      cry_q, cry_d;
    logic [1:0]         cnt_q, cnt_d;
    logic signed [31:0] prod_c;

    // Product of the registered operands, then LAT-2 further delay stages.
    always_comb begin
        prod_c   = 32'($signed(in_x_q)) * 32'($signed(in_y_q));
        res_d[0] = prod_c;
        cry_d    = '0;
        cry_d[0] = (prod_c[31:15] != {17{prod_c[15]}});
        for (int unsigned k = 1; k < PW; k++) begin
            res_d[k] = res_q[k-1];
            cry_d[k] = cry_q[k-1];
        end
        cnt_d = (cnt_q == 2'(MUL16_WARMUP)) ? cnt_q : cnt_q + 2'd1;
    end

    // Operand, product and warm-up registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            in_x_q <= '0;
            in_y_q <= '0;
            cry_q  <= '0;
            cnt_q  <= '0;
            for (int unsigned k = 0; k < PW; k++) res_q[k] <= '0;
        end else begin
            in_x_q <= i_num_x;
            in_y_q <= i_num_y;
            cry_q  <= cry_d;
            cnt_q  <= cnt_d;
            for (int unsigned k = 0; k < PW; k++) res_q[k] <= res_d[k];
        end
    end

    assign o_res = res_q[PW-1];
    assign o_cry = cry_q[PW-1];
    assign o_end = (cnt_q == 2'(MUL16_WARMUP));

endmodule

// File: rtl/mul_16bit_arbiter.sv
// Shares one multiplier among NUM_REQ requesters: round-robin issue,
// id-tagged pipeline, and a per-requester response slot.
module mul_16bit_arbiter
    import mul_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned MUL_LAT = MUL16_LAT
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [NUM_REQ-1:0]    i_req_vld,
    output logic [NUM_REQ-1:0]    o_req_rdy,
    input  logic [NUM_REQ*16-1:0] i_req_num_x,
    input  logic [NUM_REQ*16-1:0] i_req_num_y,
    output logic [NUM_REQ-1:0]    o_rsp_vld,
    input  logic [NUM_REQ-1:0]    i_rsp_rdy,
    output logic [NUM_REQ*32-1:0] o_rsp_res,
    output logic [NUM_REQ-1:0]    o_rsp_cry,
    output logic                  o_busy
);

    localparam int unsigned IW = $clog2(NUM_REQ);

    mul_arb_state_e        state_q, state_d;
    logic [IW-1:0]         ptr_q, ptr_d, win_idx;
    logic [NUM_REQ-1:0]    inflight_q, inflight_d;
    logic [NUM_REQ-1:0]    slot_full_q, slot_full_d;
    logic [NUM_REQ-1:0]    slot_cry_q, slot_cry_d;
    logic [NUM_REQ*32-1:0] slot_res_q, slot_res_d;
    mul_tag_t              tag_q [MUL_LAT];
    mul_tag_t              tag_d [MUL_LAT];
    mul_tag_t              last_c;
    logic [NUM_REQ-1:0]    elig_c, gnt_c, rdy_c;
    logic                  run_c, xfer_c;
    logic [15:0]           mul_x_c, mul_y_c;
    logic [31:0]           mul_res;
    logic                  mul_cry, mul_end;

    assign elig_c = i_req_vld & ~inflight_q & ~slot_full_q;

    arb_rr_nnbit #(.N(NUM_REQ)) u_arb (
        .i_elig (elig_c),
        .i_ptr  (ptr_q),
        .o_gnt  (gnt_c),
        .o_idx  (win_idx)
    );

    // Grants open on the same cycle the multiplier reports warm-up done.
    assign run_c  = (state_q == RUN) || mul_end;
    assign rdy_c  = run_c ? gnt_c : '0;
    assign xfer_c = |(i_req_vld & rdy_c);

    // Winner operands to the multiplier, zero when idle.
    always_comb begin
        mul_x_c = '0;
        mul_y_c = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (rdy_c[i] && i_req_vld[i]) begin
                mul_x_c = i_req_num_x[i*16 +: 16];
                mul_y_c = i_req_num_y[i*16 +: 16];
            end
        end
    end

    mul_16bit_wallace #(.LAT(MUL_LAT)) u_mul (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_num_x (mul_x_c),
        .i_num_y (mul_y_c),
        .o_res   (mul_res),
        .o_cry   (mul_cry),
        .o_end   (mul_end)
    );

    // FSM, pointer and tag pipeline next-state.
    always_comb begin
        state_d = state_q;
        if (state_q == WARMUP && mul_end) state_d = RUN;
        ptr_d    = xfer_c ? win_idx : ptr_q;
        tag_d[0] = '{vld: xfer_c, id: 3'(win_idx)};
        for (int unsigned k = 1; k < MUL_LAT; k++) tag_d[k] = tag_q[k-1];
        last_c = tag_q[MUL_LAT-1];
    end

    // Issue/retire bookkeeping and response slot capture/consume.
    always_comb begin
        inflight_d  = inflight_q;
        slot_full_d = slot_full_q & ~i_rsp_rdy;
        slot_res_d  = slot_res_q;
        slot_cry_d  = slot_cry_q;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (last_c.vld && last_c.id == 3'(i)) begin
                slot_full_d[i]         = 1'b1;
                slot_res_d[i*32 +: 32] = mul_res;
                slot_cry_d[i]          = mul_cry;
                inflight_d[i]          = 1'b0;
            end
            if (xfer_c && rdy_c[i]) inflight_d[i] = 1'b1;
        end
    end

    // State registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= WARMUP;
            ptr_q       <= IW'(NUM_REQ - 1);
            inflight_q  <= '0;
            slot_full_q <= '0;
            slot_res_q  <= '0;
            slot_cry_q  <= '0;
            for (int unsigned k = 0; k < MUL_LAT; k++) tag_q[k] <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            inflight_q  <= inflight_d;
            slot_full_q <= slot_full_d;
            slot_res_q  <= slot_res_d;
            slot_cry_q  <= slot_cry_d;
            for (int unsigned k = 0; k < MUL_LAT; k++) tag_q[k] <= tag_d[k];
        end
    end

    assign o_req_rdy = rdy_c;
    assign o_rsp_vld = slot_full_q;
    assign o_rsp_res = slot_res_q;
    assign o_rsp_cry = slot_cry_q;
    assign o_busy    = (|inflight_q) || (|slot_full_q);

endmodule

// File: tb/tb_mul_16bit_arbiter.sv
// Randomized bench for mul_16bit_arbiter against a transaction-level model:
// a requester is busy from its grant until its result is consumed, and its
// result becomes visible 1+LAT cycles after the grant.
module tb_mul_16bit_arbiter;

    localparam int unsigned N   = 4;
    localparam int unsigned LAT = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_vld = '0, req_rdy, rsp_vld, rsp_rdy = '0, rsp_cry;
    logic [N*16-1:0] nx = '0, ny = '0;
    logic [N*32-1:0] rsp_res;
    logic            busy;

    int n_chk = 0, n_pass = 0;

    bit          m_busy  [N];
    int          m_rdy_cy[N];
    logic [31:0] m_res   [N];
    logic        m_cry   [N];
    int          m_ptr = N - 1;
    int          cyc   = 0;

    always #5 clk = ~clk;

    mul_16bit_arbiter #(.NUM_REQ(N), .MUL_LAT(LAT)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_vld   (req_vld),
        .o_req_rdy   (req_rdy),
        .i_req_num_x (nx),
        .i_req_num_y (ny),
        .o_rsp_vld   (rsp_vld),
        .i_rsp_rdy   (rsp_rdy),
        .o_rsp_res   (rsp_res),
        .o_rsp_cry   (rsp_cry),
        .o_busy      (busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s cyc=%0d: got %h want %h", tag, cyc, obs, exp);
    endtask

    function automatic int sx(input logic [15:0] v);
        return int'($signed(v));
    endfunction

    // One clock cycle: drive, then compare against the model and advance it.
    task automatic step(input bit rst, input logic [N-1:0] vld, input logic [N-1:0] rrdy,
                        input bit rnd, input logic [15:0] dx, input logic [15:0] dy);
        logic [N-1:0] exp_rdy, exp_vld;
        int win, j, p;
        bit any_busy;
        @(posedge clk);
        #1;
        rst_n   = !rst;
        req_vld = vld;
        rsp_rdy = rrdy;
        for (int i = 0; i < N; i++) begin
            nx[i*16 +: 16] = rnd ? 16'($urandom) : dx;
            ny[i*16 +: 16] = rnd ? 16'($urandom) : dy;
        end
        @(negedge clk);
        if (rst) begin
            for (int i = 0; i < N; i++) m_busy[i] = 0;
            m_ptr = N - 1;
            cyc   = 0;
            return;
        end
        win = -1;
        if (cyc >= 3) begin
            for (int k = 1; k <= N; k++) begin
                j = (m_ptr + k) % N;
                if (win < 0 && vld[j] && !m_busy[j]) win = j;
            end
        end
        exp_rdy  = (win >= 0) ? (N'(1) << win) : '0;
        any_busy = 0;
        for (int i = 0; i < N; i++) begin
            exp_vld[i] = m_busy[i] && (cyc >= m_rdy_cy[i]);
            any_busy   = any_busy | m_busy[i];
        end
        check("req_rdy", 64'(req_rdy), 64'(exp_rdy));
        check("rsp_vld", 64'(rsp_vld), 64'(exp_vld));
        check("busy", 64'(busy), 64'(any_busy));
        for (int i = 0; i < N; i++) begin
            if (exp_vld[i]) begin
                check($sformatf("rsp_res%0d", i), 64'(rsp_res[i*32 +: 32]), 64'(m_res[i]));
                check($sformatf("rsp_cry%0d", i), 64'(rsp_cry[i]), 64'(m_cry[i]));
                if (rrdy[i]) m_busy[i] = 0;
            end
        end
        if (win >= 0) begin
            p             = sx(nx[win*16 +: 16]) * sx(ny[win*16 +: 16]);
            m_busy[win]   = 1;
            m_rdy_cy[win] = cyc + 1 + LAT;
            m_res[win]    = 32'(p);
            m_cry[win]    = (p < -32768) || (p > 32767);
            m_ptr         = win;
        end
        cyc++;
    endtask

    task automatic drain();
        for (int i = 0; i < 6; i++) step(0, '0, '1, 1, 16'h0, 16'h0);
    endtask

    // Lone request on an idle block; result checked against a fixed constant.
    task automatic op(input int r, input logic [15:0] x, input logic [15:0] y, input logic [31:0] want);
        step(0, N'(1) << r, '1, 0, x, y);
        step(0, '0, '1, 0, x, y);
        step(0, '0, '1, 0, x, y);
        step(0, '0, '0, 0, x, y);
        check($sformatf("op_res%0d", r), 64'(rsp_res[r*32 +: 32]), 64'(want));
        check($sformatf("op_vld%0d", r), 64'(rsp_vld), 64'(N'(1) << r));
        step(0, '0, '1, 0, x, y);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) step(1, '0, '0, 1, 16'h0, 16'h0);
        // Warm-up: requester 0 waits from reset release
        for (int i = 0; i < 10; i++) step(0, 4'b0001, '1, 1, 16'h0, 16'h0);
        drain();
        op(2, 16'h0003, 16'hFFFB, 32'hFFFF_FFF1);
        op(0, 16'h8000, 16'h8000, 32'h4000_0000);
        op(1, 16'h7FFF, 16'h8000, 32'hC000_8000);
        op(3, 16'h0000, 16'h1234, 32'h0000_0000);
        drain();
        // Round robin, all requesters continuously valid
        for (int i = 0; i < 24; i++) step(0, '1, '1, 1, 16'h0, 16'h0);
        // Backpressure on requester 1, then release
        for (int i = 0; i < 30; i++) step(0, '1, 4'b1101, 1, 16'h0, 16'h0);
        for (int i = 0; i < 12; i++) step(0, '1, '1, 1, 16'h0, 16'h0);
        // Random traffic
        for (int i = 0; i < 400; i++)
            step(0, N'($urandom), N'($urandom), 1, 16'h0, 16'h0);
        // Reset with operations in flight
        drain();
        for (int i = 0; i < 2; i++) step(0, '1, '1, 1, 16'h0, 16'h0);
        step(1, '1, '1, 1, 16'h0, 16'h0);
        for (int i = 0; i < 12; i++) step(0, '1, '1, 1, 16'h0, 16'h0);
        drain();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mul_16bit_arbiter.md
# mul_16bit_arbiter

Shares a single `mul_16bit_wallace` instance among `NUM_REQ` requesters that issue signed 16x16 multiplies. Requests are accepted by round-robin arbitration, at most one per cycle, and accepted operations are tagged through the multiplier's fixed pipeline. Each result is returned to its originating requester through a per-requester valid/ready response slot. The block sits between the integer execute lanes and the multiplier datapath and also hides the multiplier's post-reset warm-up.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `MUL_LAT`, default 2: clock edges from multiplier input to valid `o_res`.
- `i_clk` in 1: clock.
- `i_rst_n` in 1: reset, synchronous, active-low.
- `i_req_vld` in `NUM_REQ`: per-requester request valid.
- `o_req_rdy` out `NUM_REQ`: per-requester grant (one-hot or zero).
- `i_req_num_x` in `NUM_REQ`x16: signed multiplicand per requester.
- `i_req_num_y` in `NUM_REQ`x16: signed multiplier per requester.
- `o_rsp_vld` out `NUM_REQ`: response slot full.
- `i_rsp_rdy` in `NUM_REQ`: requester consumes response.
- `o_rsp_res` out `NUM_REQ`x32: signed product held in the slot.
- `o_rsp_cry` out `NUM_REQ`: multiplier carry captured with the product.
- `o_busy` out 1: any operation in flight or any slot full.

## Operation
- FSM has two states:
  - WARMUP: the reset state. All `o_req_rdy` are 0. Moves to RUN on the first cycle in which the multiplier's `o_end` is 1.
  - RUN: never leaves except on reset.
- A requester is eligible when `i_req_vld[i]` is 1, `inflight[i]` is 0, and `slot_full[i]` is 0.
- Round-robin grant: search eligible requesters starting at `ptr+1`, wrapping modulo `NUM_REQ`. `o_req_rdy` is the one-hot winner in RUN, otherwise 0.
- `o_req_rdy` depends combinationally on `i_req_vld`. Requesters must not make `vld` depend on `rdy`.
- A transfer occurs when `vld & rdy` in the same cycle. On transfer:
  - `ptr` takes the winner index.
  - `inflight[winner]` is set.
  - The winner's x and y drive the multiplier inputs.
  - With no transfer, the multiplier inputs are driven to 0.
- Tag pipeline: `MUL_LAT` stages of {valid, id}, shifted every cycle. Stage 0 loads {transfer, winner}.
- When the last tag stage is valid, the multiplier `o_res`/`o_cry` are captured into `slot[id]`. The same edge sets `slot_full[id]` and clears `inflight[id]`.
- Slot `i` is cleared on `o_rsp_vld[i] & i_rsp_rdy[i]`. Capture and clear never target the same slot in one cycle, because issue requires the slot to be empty.
- `o_rsp_res` and `o_rsp_cry` hold their value while `o_rsp_vld` is 1. They are don't-care while it is 0; the bench checks them only when valid.
- Products are two's-complement signed 32-bit values; no truncation or saturation.

## Timing
- Reset values: `ptr` = `NUM_REQ-1`, so requester 0 wins first. All `o_req_rdy`, `o_rsp_vld`, `o_rsp_res`, `o_rsp_cry`, `o_busy` are 0. State is WARMUP and all tags are invalid.
- The multiplier is reset by the same `i_rst_n`. After reset deasserts, `o_end` rises at cycle 3, so the first grant is possible in cycle 3.
- Latency: a transfer in cycle t gives `o_rsp_vld` = 1 from cycle t+1+`MUL_LAT` (t+3 by default).
- Throughput is one grant per cycle across requesters. A single requester can issue at most once per `MUL_LAT`+2 cycles when its response is consumed immediately.
- Reset mid-operation: in-flight tags are discarded and slots are cleared. No response is produced for pre-reset requests. The block re-enters WARMUP.

## Structure
- Package `mul_pkg` holds:
  - constant `MUL16_LAT` = 2, the default for `MUL_LAT`;
  - constant `MUL16_WARMUP` = 3;
  - typedef `mul_tag_t` {logic vld; logic [2:0] id};
  - enum `mul_arb_state_e` {WARMUP, RUN}.
- Sub-module `arb_rr_nnbit` (parameter `N`): inputs are the eligible vector and `ptr`; output is the one-hot grant plus the encoded index. It is purely combinational and reusable by other shared units.
- The top level instantiates `arb_rr_nnbit` and `mul_16bit_wallace`, and contains the FSM, tag pipeline, `inflight` register, and slot registers.

## Test plan
- Warm-up: `i_req_vld[0]` = 1 from reset release.
  - `o_req_rdy[0]` is 0 in cycles 0-2 and 1 in cycle 3.
  - `o_rsp_vld[0]` rises in cycle 6.
- Single op: requester 2 sends x=3, y=-5 (0xFFFB). Require `o_rsp_res[2]` = 0xFFFF_FFF1 three cycles after the transfer, and no other `o_rsp_vld`.
- Extremes:
  - 0x8000 * 0x8000 returns 0x4000_0000.
  - 0x7FFF * 0x8000 returns 0xC000_8000.
  - 0 * 0x1234 returns 0.
- Round robin: all four requesters continuously valid with `i_rsp_rdy` = all 1.
  - Grants go 0,1,2,3,0,1... in consecutive cycles.
  - All products are correct, in order per requester.
- Backpressure: hold `i_rsp_rdy[1]` = 0 after its first result.
  - Requester 1 is not granted again and its slot value holds.
  - Requesters 0, 2 and 3 continue in rotation.
  - Releasing `i_rsp_rdy[1]` frees the slot; requester 1 is re-granted when the round-robin pointer next reaches it.
- Reset mid-op: assert `i_rst_n` = 0 for one cycle while 2 ops are in flight.
  - All outputs are 0 after the reset edge.
  - No stale `o_rsp_vld` appears.
  - The next grant occurs no earlier than cycle 3 after reset release.
